// File: rtl/asic_iopoc_seq.sv
// asic_iopoc_seq: power-on-control sequencer holding the pad ring safe while banks ramp up/down in order
module asic_iopoc_seq #(
   parameter int NBANKS      = 4,
   parameter int POC_CYCLES  = 64,
   parameter int GAP_CYCLES  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwr_good,
   input  logic              off_req,
   output logic              poc,
   output logic [NBANKS-1:0] bank_en,
   output logic              io_ready,
   output logic [2:0]        state
);
   localparam int CW = $clog2((POC_CYCLES > GAP_CYCLES ? POC_CYCLES : GAP_CYCLES) + 1);
   localparam logic [CW-1:0] POC_LAST = CW'(POC_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   typedef enum logic [2:0] {IDLE = 3'd0, HOLD = 3'd1, RAMP = 3'd2, ON = 3'd3, DOWN = 3'd4} state_t;
   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state, w_state;
   logic [CW-1:0]          r_cnt, w_cnt;
   logic [NBANKS-1:0]      r_bank, w_bank;
   logic                   r_poc, w_poc, r_rdy, w_rdy;
   logic                   w_pg;
   assign w_pg = r_sync[SYNC_STAGES-1];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bank  <= '0;
         r_poc   <= 1'b1;
         r_rdy   <= 1'b0;
      end else begin
         r_sync  <= {r_sync[SYNC_STAGES-2:0], pwr_good};
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_bank  <= w_bank;
         r_poc   <= w_poc;
         r_rdy   <= w_rdy;
      end
   end
   // Outputs are computed alongside the next state so every pad-facing signal leaves a flop.
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_bank  = r_bank;
      w_poc   = r_poc;
      w_rdy   = r_rdy;
      if (!w_pg && r_state != IDLE) begin
         w_state = IDLE;
         w_cnt   = '0;
         w_bank  = '0;
         w_poc   = 1'b1;
         w_rdy   = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               w_cnt = '0;
               if (w_pg && !off_req) w_state = HOLD;
            end
            HOLD: begin
               w_cnt = r_cnt + CW'(1);
               if (r_cnt == POC_LAST) begin
                  w_state = RAMP;
                  w_cnt   = '0;
                  w_bank  = NBANKS'(1);
                  w_poc   = 1'b0;
               end
            end
            RAMP: begin
               w_cnt = r_cnt + CW'(1);
               if (r_cnt == GAP_LAST) begin
                  w_cnt = '0;
                  if (&r_bank) begin
                     w_state = ON;
                     w_rdy   = 1'b1;
                  end else
                     w_bank = (r_bank << 1) | NBANKS'(1);
               end
            end
            ON: begin
               if (off_req) begin
                  w_state = DOWN;
                  w_cnt   = '0;
                  w_bank  = r_bank >> 1;
                  w_rdy   = 1'b0;
               end
            end
            DOWN: begin
               w_cnt = r_cnt + CW'(1);
               if (r_cnt == GAP_LAST) begin
                  w_cnt = '0;
                  if (r_bank == '0) begin
                     w_state = IDLE;
                     w_poc   = 1'b1;
                  end else
                     w_bank = r_bank >> 1;
               end
            end
            default: begin
               w_state = IDLE;
               w_cnt   = '0;
               w_bank  = '0;
               w_poc   = 1'b1;
               w_rdy   = 1'b0;
            end
         endcase
      end
   end
   assign poc      = r_poc;
   assign bank_en  = r_bank;
   assign io_ready = r_rdy;
   assign state    = r_state;
endmodule

// File: tb/tb_asic_iopoc_seq.sv
// tb_asic_iopoc_seq: checks two sequencer configurations against a phase/elapsed-time reference model
module tb_asic_iopoc_seq;
   logic       clk, rst, pwr_good, off_req;
   logic       poc_a, rdy_a, poc_b, rdy_b;
   logic [3:0] bank_a;
   logic [0:0] bank_b;
   logic [2:0] st_a, st_b;
   int         total = 0, bad = 0;

   typedef struct {int phase; int t; logic [1:0] sy;} model_t;
   typedef struct {logic [2:0] st; logic poc; logic rdy; logic [3:0] bank;} exp_t;
   model_t ma, mb;

   asic_iopoc_seq #(.NBANKS(4), .POC_CYCLES(64), .GAP_CYCLES(8), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .pwr_good(pwr_good), .off_req(off_req),
      .poc(poc_a), .bank_en(bank_a), .io_ready(rdy_a), .state(st_a));
   asic_iopoc_seq #(.NBANKS(1), .POC_CYCLES(1), .GAP_CYCLES(1), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst(rst), .pwr_good(pwr_good), .off_req(off_req),
      .poc(poc_b), .bank_en(bank_b), .io_ready(rdy_b), .state(st_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // phase: 0 idle, 1 powering up (hold then ramp), 2 on, 3 powering down; t = cycles in phase
   function automatic model_t step_m(model_t m, int nb, int pc, int gp, logic pg, logic off, logic r);
      model_t n;
      logic   pgs;
      n = m;
      if (r) begin
         n.phase = 0; n.t = 0; n.sy = 2'b00;
         return n;
      end
      pgs  = m.sy[1];
      n.sy = {m.sy[0], pg};
      if (m.phase != 0 && !pgs) begin
         n.phase = 0; n.t = 0;
      end else if (m.phase == 0) begin
         if (pgs && !off) begin n.phase = 1; n.t = 0; end
      end else if (m.phase == 1) begin
         n.t = m.t + 1;
         if (n.t == pc + nb * gp) begin n.phase = 2; n.t = 0; end
      end else if (m.phase == 2) begin
         if (off) begin n.phase = 3; n.t = 0; end
      end else begin
         n.t = m.t + 1;
         if (n.t == nb * gp) begin n.phase = 0; n.t = 0; end
      end
      return n;
   endfunction

   function automatic exp_t expect_of(model_t m, int nb, int pc, int gp);
      exp_t e;
      e.st = 3'd0; e.poc = 1'b1; e.rdy = 1'b0; e.bank = 4'd0;
      if (m.phase == 1) begin
         if (m.t < pc) e.st = 3'd1;
         else begin
            e.st = 3'd2; e.poc = 1'b0;
            e.bank = 4'((1 << ((m.t - pc) / gp + 1)) - 1);
         end
      end else if (m.phase == 2) begin
         e.st = 3'd3; e.poc = 1'b0; e.rdy = 1'b1;
         e.bank = 4'((1 << nb) - 1);
      end else if (m.phase == 3) begin
         e.st = 3'd4; e.poc = 1'b0;
         e.bank = 4'((1 << (nb - 1 - m.t / gp)) - 1);
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [2:0] st, logic p, logic r, logic [3:0] b, exp_t e);
      total += 5;
      assert (st === e.st) else begin bad++; $error("FAIL %s state got=%0d exp=%0d", tag, st, e.st); end
      assert (p === e.poc) else begin bad++; $error("FAIL %s poc got=%b exp=%b", tag, p, e.poc); end
      assert (r === e.rdy) else begin bad++; $error("FAIL %s io_ready got=%b exp=%b", tag, r, e.rdy); end
      assert (b === e.bank) else begin bad++; $error("FAIL %s bank_en got=%b exp=%b", tag, b, e.bank); end
      assert (!(b != 4'd0 && p !== 1'b0)) else begin bad++; $error("FAIL %s safe bank_en=%b poc=%b exp poc=0", tag, b, p); end
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      ma = step_m(ma, 4, 64, 8, pwr_good, off_req, rst);
      mb = step_m(mb, 1, 1, 1, pwr_good, off_req, rst);
      #1;
      chk({tag, "_a"}, st_a, poc_a, rdy_a, bank_a, expect_of(ma, 4, 64, 8));
      chk({tag, "_b"}, st_b, poc_b, rdy_b, {3'b000, bank_b}, expect_of(mb, 1, 1, 1));
   endtask

   task automatic run(string tag, int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      ma.phase = 0; ma.t = 0; ma.sy = 2'b00;
      mb = ma;
      rst = 1'b1; pwr_good = 1'b0; off_req = 1'b0;
      run("reset", 2);
      rst = 1'b0;
      run("idle", 3);
      pwr_good = 1'b1;
      run("powerup", 110);
      off_req = 1'b1;
      tick("off");
      off_req = 1'b0;
      run("down", 40);
      pwr_good = 1'b0;
      run("lose_idle", 5);
      pwr_good = 1'b1;
      run("ramp2", 77);
      pwr_good = 1'b0;
      run("supply_loss", 10);
      pwr_good = 1'b1;
      run("reramp", 105);
      pwr_good = 1'b0;
      run("drop", 5);
      pwr_good = 1'b1;
      run("hold", 10);
      off_req = 1'b1;
      run("off_in_hold", 140);
      off_req = 1'b0;
      run("release", 110);
      rst = 1'b1;
      tick("rst_on");
      rst = 1'b0;
      run("refill", 110);
      off_req = 1'b1;
      run("enter_down", 3);
      rst = 1'b1;
      tick("rst_down");
      rst = 1'b0; off_req = 1'b0;
      run("after_rst", 20);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) pwr_good = ~pwr_good;
         if ($urandom_range(0, 59) == 0) off_req = ~off_req;
         rst = ($urandom_range(0, 1499) == 0);
         tick("rand");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
